// File: rtl/audio_volume_meter_pkg.sv
// Shared types and helpers for the microphone volume meter: quantiser FSM
// encoding, level width and the per-level threshold function.
package audio_volume_meter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StQuant  = 2'd1,
    StUpdate = 2'd2
  } quant_state_e;

  function automatic int unsigned level_w(input int unsigned max_level);
    return $clog2(max_level + 1);
  endfunction

  // Threshold for level k: floor(k * half / max_level)
  function automatic int unsigned th(input int unsigned k, input int unsigned half,
                                     input int unsigned max_level);
    return (k * half) / max_level;
  endfunction

endpackage

// File: rtl/audio_volume_meter_level_quantiser.sv
// Sequential peak-to-level quantiser: one threshold compare per cycle, fixed
// latency, raw level presented with a one-cycle done in the update state.
module audio_volume_meter_level_quantiser
  import audio_volume_meter_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 12,
  parameter int unsigned MAX_LEVEL = 9
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          start,
  input  logic [SAMPLE_W-1:0]           snapshot,
  output logic [level_w(MAX_LEVEL)-1:0] raw,
  output logic                          done,
  output logic                          busy
);

  localparam int unsigned LevelW = level_w(MAX_LEVEL);
  localparam int unsigned KW     = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int unsigned Half   = 2 ** (SAMPLE_W - 1);
  localparam logic [KW-1:0] LastK = KW'(MAX_LEVEL - 1);

  logic [SAMPLE_W-1:0] th_tab [MAX_LEVEL];

  for (genvar g = 0; g < MAX_LEVEL; g++) begin : g_th
    assign th_tab[g] = SAMPLE_W'(th(g, Half, MAX_LEVEL));
  end

  quant_state_e        state_q;
  logic [KW-1:0]       k_q;
  logic [LevelW-1:0]   raw_q;
  logic [SAMPLE_W-1:0] snap_q;
  logic                done_q;
  logic                busy_q;

  // The k = 0 compare is made on the start cycle against the live snapshot,
  // so the last compare lands MAX_LEVEL-1 cycles later.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      k_q     <= '0;
      raw_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            snap_q <= snapshot;
            raw_q  <= LevelW'(snapshot > th_tab[0]);
            k_q    <= KW'(1);
            busy_q <= 1'b1;
            if (MAX_LEVEL == 1) begin
              state_q <= StUpdate;
              done_q  <= 1'b1;
            end else begin
              state_q <= StQuant;
            end
          end
        end
        StQuant: begin
          raw_q <= raw_q + LevelW'(snap_q > th_tab[k_q]);
          if (k_q == LastK) begin
            state_q <= StUpdate;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StUpdate: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign raw  = raw_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/audio_volume_meter.sv
// Microphone volume meter: windowed full-wave peak about mid-scale, quantised
// to a 0..MAX_LEVEL level with optional peak-hold decay and clip detection.
module audio_volume_meter
  import audio_volume_meter_pkg::*;
#(
  parameter int unsigned SAMPLE_W       = 12,
  parameter int unsigned WINDOW_SAMPLES = 4000,
  parameter int unsigned MAX_LEVEL      = 9,
  parameter int unsigned DECAY_WINDOWS  = 2,
  parameter int unsigned CLIP_RUN       = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          sample_valid,
  input  logic [SAMPLE_W-1:0]           sample,
  input  logic                          hold_en,
  output logic [level_w(MAX_LEVEL)-1:0] level,
  output logic [MAX_LEVEL-1:0]          led,
  output logic                          level_valid,
  output logic                          clip,
  output logic                          busy
);

  localparam int unsigned LevelW = level_w(MAX_LEVEL);
  localparam int unsigned CntW   = $clog2(WINDOW_SAMPLES);
  localparam int unsigned RunW   = $clog2(CLIP_RUN + 1);
  localparam int unsigned DecW   = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;

  localparam logic [SAMPLE_W-1:0] Half    = SAMPLE_W'(2 ** (SAMPLE_W - 1));
  localparam logic [CntW-1:0]     LastCnt = CntW'(WINDOW_SAMPLES - 1);
  localparam logic [RunW-1:0]     RunMax  = RunW'(CLIP_RUN);
  localparam logic [DecW-1:0]     DecLast = DecW'(DECAY_WINDOWS - 1);

  logic [CntW-1:0]     cnt_q;
  logic [SAMPLE_W-1:0] peak_q;
  logic [RunW-1:0]     run_q;
  logic                close_q;
  logic                clip_seen_q;
  logic                clip_snap_q;

  logic [SAMPLE_W-1:0] mag;
  logic                rail;
  logic                win_last;
  logic                close_d;
  logic [RunW-1:0]     run_d;
  logic                clip_hit;

  always_comb begin
    mag      = (sample >= Half) ? (sample - Half) : (Half - sample);
    rail     = (sample == '0) || (sample == '1);
    win_last = (cnt_q == LastCnt);
    // The counter parks on its last value during the close cycle.
    close_d  = sample_valid && win_last && !close_q;
    run_d    = run_q;
    if (sample_valid) begin
      if (!rail)                run_d = '0;
      else if (run_q != RunMax) run_d = run_q + 1'b1;
    end
    clip_hit = sample_valid && rail && (run_d == RunMax);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_q       <= '0;
      peak_q      <= '0;
      run_q       <= '0;
      close_q     <= 1'b0;
      clip_seen_q <= 1'b0;
      clip_snap_q <= 1'b0;
    end else begin
      close_q <= close_d;
      run_q   <= run_d;
      if (close_q) begin
        cnt_q       <= sample_valid ? CntW'(1) : '0;
        peak_q      <= sample_valid ? mag : '0;
        clip_seen_q <= clip_hit;
        clip_snap_q <= clip_seen_q;
      end else if (sample_valid) begin
        if (!win_last)     cnt_q <= cnt_q + 1'b1;
        if (mag > peak_q)  peak_q <= mag;
        if (clip_hit)      clip_seen_q <= 1'b1;
      end
    end
  end

  logic [LevelW-1:0] raw;
  logic              done;

  audio_volume_meter_level_quantiser #(
    .SAMPLE_W (SAMPLE_W),
    .MAX_LEVEL(MAX_LEVEL)
  ) u_quant (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .start   (close_q),
    .snapshot(peak_q),
    .raw     (raw),
    .done    (done),
    .busy    (busy)
  );

  logic [LevelW-1:0]    level_q, level_d;
  logic [DecW-1:0]      decay_q, decay_d;
  logic [MAX_LEVEL-1:0] led_q, led_d;
  logic                 clip_q;
  logic                 level_valid_q;

  always_comb begin
    level_d = level_q;
    decay_d = decay_q;
    if (!hold_en || (raw >= level_q)) begin
      level_d = raw;
      decay_d = '0;
    end else if (decay_q == DecLast) begin
      level_d = level_q - 1'b1;
      decay_d = '0;
    end else begin
      decay_d = decay_q + 1'b1;
    end
    led_d = '0;
    for (int i = 0; i < MAX_LEVEL; i++) begin
      led_d[i] = (level_d > LevelW'(i));
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      level_q       <= '0;
      decay_q       <= '0;
      led_q         <= '0;
      clip_q        <= 1'b0;
      level_valid_q <= 1'b0;
    end else begin
      level_valid_q <= done;
      if (done) begin
        level_q <= level_d;
        decay_q <= decay_d;
        led_q   <= led_d;
        clip_q  <= clip_snap_q;
      end
    end
  end

  assign level       = level_q;
  assign led         = led_q;
  assign clip        = clip_q;
  assign level_valid = level_valid_q;

endmodule

// File: tb/tb_audio_volume_meter.sv
// Self-checking bench for audio_volume_meter: randomized windows compared
// against a window/peak/threshold reference model.
module tb_audio_volume_meter;

  localparam int SW   = 12;
  localparam int WS   = 16;
  localparam int ML   = 9;
  localparam int DW   = 2;
  localparam int CR   = 4;
  localparam int HALF = 2048;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic        hold_en = 1'b0;
  logic [3:0]  level;
  logic [8:0]  led;
  logic        level_valid, clip, busy;

  audio_volume_meter #(
    .SAMPLE_W(SW), .WINDOW_SAMPLES(WS), .MAX_LEVEL(ML), .DECAY_WINDOWS(DW), .CLIP_RUN(CR)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .sample_valid(sample_valid), .sample(sample),
    .hold_en(hold_en), .level(level), .led(led), .level_valid(level_valid),
    .clip(clip), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {int level; int led; int clip; int cyc;} ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_e;
  int  obs_rd = 0;
  int  tests = 0, fails = 0;
  int  cyc = 0;

  int m_cnt = 0, m_peak = 0, m_run = 0, m_level = 0, m_decay = 0;
  bit m_clip = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    if (!RESET && level_valid) begin
      mon_e.level = int'(level);
      mon_e.led   = int'(led);
      mon_e.clip  = int'(clip);
      mon_e.cyc   = cyc;
      obs_q.push_back(mon_e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_cnt = 0; m_peak = 0; m_run = 0; m_level = 0; m_decay = 0; m_clip = 0;
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic model_accept(input int s);
    int mag, raw;
    ev_t e;
    mag = (s >= HALF) ? s - HALF : HALF - s;
    if (mag > m_peak) m_peak = mag;
    if (s == 0 || s == 4095) begin
      m_run++;
      if (m_run >= CR) m_clip = 1;
    end else begin
      m_run = 0;
    end
    m_cnt++;
    if (m_cnt == WS) begin
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL close_while_busy: busy=%b, required 0", busy);
      end
      raw = 0;
      for (int k = 0; k < ML; k++) if (m_peak > (k * HALF) / ML) raw++;
      if (!hold_en || raw >= m_level) begin
        m_level = raw; m_decay = 0;
      end else if (m_decay == DW - 1) begin
        m_level--; m_decay = 0;
      end else begin
        m_decay++;
      end
      e.level = m_level;
      e.led   = (1 << m_level) - 1;
      e.clip  = int'(m_clip);
      e.cyc   = cyc;
      exp_q.push_back(e);
      m_cnt = 0; m_peak = 0; m_clip = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int s);
    sample_valid = 1'b1;
    sample = 12'(s);
    model_accept(s);
    @(negedge CLOCK);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  function automatic int quiet();
    return HALF - 50 + int'($urandom_range(0, 100));
  endfunction

  task automatic send_window(input int vals[WS], input bit gap_last);
    for (int i = 0; i < WS; i++) begin
      drive(vals[i]);
      if (i != WS - 1 || gap_last) idle($urandom_range(0, 2));
    end
  endtask

  task automatic check_window(input string name);
    int n = 0;
    ev_t e, o;
    while (obs_q.size() <= obs_rd && n < 60) begin @(negedge CLOCK); n++; end
    tests++;
    if (obs_q.size() <= obs_rd || exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s_event: level_valid events=%0d, required windows=%0d",
               name, obs_q.size() - obs_rd, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    o = obs_q[obs_rd];
    obs_rd++;
    tests++;
    if (o.cyc - e.cyc != ML + 2) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, o.cyc - e.cyc, ML + 2);
    end
    tests++;
    if (o.level != e.level) begin
      fails++; $display("FAIL %s_level: got %0d, required %0d", name, o.level, e.level);
    end
    tests++;
    if (o.led != e.led) begin
      fails++; $display("FAIL %s_led: got %b, required %b", name, 9'(o.led), 9'(e.led));
    end
    tests++;
    if (o.clip != e.clip) begin
      fails++; $display("FAIL %s_clip: got %0d, required %0d", name, o.clip, e.clip);
    end
  endtask

  task automatic check_no_events(input string name);
    tests++;
    if (obs_q.size() != obs_rd) begin
      fails++;
      $display("FAIL %s_spurious: got %0d unexpected level_valid, required 0",
               name, obs_q.size() - obs_rd);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(3);
    tests++;
    if (level !== 4'd0 || led !== 9'd0 || clip !== 1'b0 || busy !== 1'b0 || level_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: level=%0d led=%b clip=%b busy=%b lv=%b, required all 0",
               level, led, clip, busy, level_valid);
    end
    RESET = 1'b0;
    model_reset();
    idle(2);
  endtask

  task automatic test_single_peak();
    int v[WS];
    int pos = $urandom_range(0, WS - 1);
    hold_en = 1'b0;
    for (int i = 0; i < WS; i++) v[i] = (i == pos) ? HALF + 228 : HALF;
    send_window(v, 1'b1);
    check_window("single_peak");
  endtask

  task automatic test_thresholds();
    int mags[7] = '{0, 1, 227, 228, 1820, 1821, 2048};
    int v[WS];
    int pos;
    hold_en = 1'b0;
    for (int t = 0; t < 7; t++) begin
      pos = $urandom_range(0, WS - 1);
      for (int i = 0; i < WS; i++) v[i] = HALF;
      v[pos] = (mags[t] == 2048) ? 0 : HALF + mags[t];
      send_window(v, 1'b1);
      check_window($sformatf("threshold_mag%0d", mags[t]));
    end
  endtask

  task automatic test_hold_decay();
    int v[WS];
    hold_en = 1'b1;
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < WS; i++) v[i] = HALF;
      if (w == 0 || w == 6) v[$urandom_range(0, WS - 1)] = 0;
      send_window(v, 1'b1);
      check_window($sformatf("hold_w%0d", w));
    end
    hold_en = 1'b0;
  endtask

  task automatic test_clip();
    int v[WS];
    hold_en = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WS; i++) v[i] = quiet();
      if (w == 0) for (int i = 2; i < 5; i++) v[i] = 4095;
      if (w == 1) for (int i = 6; i < 10; i++) v[i] = 4095;
      send_window(v, 1'b1);
      check_window($sformatf("clip_w%0d", w));
    end
  endtask

  task automatic test_back_to_back();
    int v[WS];
    hold_en = 1'b0;
    for (int i = 0; i < WS; i++) v[i] = quiet();
    send_window(v, 1'b0);
    drive(0);  // lands in the next window
    for (int i = 1; i < WS; i++) begin
      drive(quiet());
      idle($urandom_range(0, 2));
    end
    check_window("b2b_closing");
    check_window("b2b_next");
  endtask

  task automatic test_reset_mid_quant();
    int v[WS];
    hold_en = 1'b0;
    for (int i = 0; i < WS; i++) v[i] = (i == 5) ? 0 : HALF;
    send_window(v, 1'b1);
    check_window("pre_reset_loud");
    for (int i = 0; i < WS; i++) v[i] = quiet();
    send_window(v, 1'b0);
    idle(2);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL mid_quant_busy: got %b, required 1", busy);
    end
    RESET = 1'b1;
    #1;
    tests++;
    if (level !== 4'd0 || led !== 9'd0 || clip !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_quant_reset: level=%0d led=%b clip=%b busy=%b, required all 0",
               level, led, clip, busy);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    model_reset();
    idle(20);
    check_no_events("mid_quant_abort");
    for (int i = 0; i < WS; i++) v[i] = $urandom_range(0, 4095);
    send_window(v, 1'b1);
    check_window("post_reset");
  endtask

  task automatic test_random();
    int r;
    for (int b = 0; b < 2; b++) begin
      hold_en = $urandom_range(0, 1);
      for (int i = 0; i < 3 * WS; i++) begin
        r = $urandom_range(0, 9);
        drive(r < 3 ? 4095 : (r < 4 ? 0 : int'($urandom_range(0, 4095))));
        idle($urandom_range(0, 2));
      end
      for (int w = 0; w < 3; w++) check_window($sformatf("random_b%0d_w%0d", b, w));
      idle(15);
      check_no_events($sformatf("random_b%0d", b));
    end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_thresholds();
    test_hold_decay();
    test_clip();
    test_back_to_back();
    test_reset_mid_quant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
